// File: rtl/decoder_n_hold_if.sv
// decoder_n_hold_if
//   Groups the code-in handshake and the decoded-select outputs of
//   decoder_n_hold into one bundle.
//   Signals:
//     in_valid  : source -> block, in_code is valid this cycle
//     in_ready  : block -> source, a code can be accepted this cycle
//     in_code   : source -> block, binary code (IN_W bits)
//     out_valid : block -> consumer, out_data holds a decoded value
//     out_data  : block -> consumer, decoded select vector (1<<IN_W bits)
//     out_busy  : block -> consumer, high while a code is being held
//   Modports: master = code source / consumer side, slave = decoder side.
interface decoder_n_hold_if #(
  parameter int IN_W = 3
) ();
  localparam int OUT_W = 1 << IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_busy;

  modport master (
    output in_valid, in_code,
    input  in_ready, out_valid, out_data, out_busy
  );

  modport slave (
    input  in_valid, in_code,
    output in_ready, out_valid, out_data, out_busy
  );
endinterface

// File: rtl/decoder_n_hold.sv
// decoder_n_hold
//   Registered binary-to-one-hot / thermometer decoder with a valid/ready
//   input handshake. Every accepted code is decoded into out_data and held
//   stable, with out_valid high, for exactly HOLD_CYC cycles.
//   Parameters:
//     IN_W     : input code width, output width is 1<<IN_W
//     HOLD_CYC : hold time in cycles per accepted code (1..65535)
//     OUT_MODE : 0 = one-hot, 1 = thermometer
//   Ports:
//     sys_clk   : system clock, rising edge
//     sys_rst_n : asynchronous active-low reset
//     bus       : decoder_n_hold_if.slave (handshake + decoded outputs)
//   Build option:
//     DECODER_N_HOLD_RETRIG_EN : when defined, a new code may be accepted
//     while holding; it replaces the held value and restarts the hold time.
module decoder_n_hold #(
  parameter int IN_W     = 3,
  parameter int HOLD_CYC = 4,
  parameter int OUT_MODE = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  decoder_n_hold_if.slave  bus
);
  localparam int OUT_W     = 1 << IN_W;
  localparam int CNT_W_RAW = $clog2(HOLD_CYC + 1);
  localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_data_nxt;
  logic             w_ready;
  logic             w_accept;

  // Thermometer is formed one bit wider than the output so that the top
  // code (2<<code overflowing OUT_W) still yields all ones after truncation.
  function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] code);
    if (OUT_MODE != 0)
      decode = OUT_W'(((OUT_W+1)'(2) << code) - (OUT_W+1)'(1));
    else
      decode = OUT_W'(1) << code;
  endfunction

  // in_ready is forced low while reset is asserted so no code is taken
  // across the reset release edge.
`ifdef DECODER_N_HOLD_RETRIG_EN
  assign w_ready = sys_rst_n;
`else
  assign w_ready = sys_rst_n && (r_state == IDLE);
`endif

  assign w_accept = bus.in_valid && w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = CNT_LOAD;
          w_data_nxt  = decode(bus.in_code);
        end
      end
      HOLD: begin
`ifdef DECODER_N_HOLD_RETRIG_EN
        // A new code restarts the hold; this takes priority over expiry.
        if (w_accept) begin
          w_cnt_nxt  = CNT_LOAD;
          w_data_nxt = decode(bus.in_code);
        end else
`endif
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_data_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_data_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // out_valid follows the state register directly, so an asynchronous
  // reset clears it at once together with out_data.
  assign bus.in_ready  = w_ready;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_busy  = (r_state == HOLD);
  assign bus.out_data  = r_data;
endmodule
